writeback_assembler: RTL and testbench

Writeback stage of the SIMD pipeline. It drives the write ports of the scalar and vector register files in decode: RegWriteW, WA3W, ResultW, RegWriteVW and ResultVW. It selects and registers scalar and vector results from the memory stage. Vector loads come from the 32-bit data memory as V/N beats, which this block assembles into one V-bit vector before committing it; while it collects, it asserts a stall to the hazard unit.

---
 rtl/wb_pkg.sv | 11 +
 rtl/writeback_assembler_vector_beat_buffer.sv | 26 ++
 rtl/writeback_assembler.sv | 80 ++++++++
 tb/tb_writeback_assembler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding and sizing helpers for the writeback assembler
package wb_pkg;
  typedef enum logic {IDLE, COLLECT} state_t;
  localparam int DEF_N = 32;
  localparam int DEF_V = 256;
  localparam int BEATS = DEF_V / DEF_N;
  localparam int CNT_W = $clog2(BEATS);
  function automatic int cnt_width(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/writeback_assembler_vector_beat_buffer.sv
// vector_beat_buffer: lane-indexed assembly register for vector-load beats
module vector_beat_buffer #(
  parameter int N  = 32,
  parameter int V  = 256,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [CW-1:0] idx_i,
  input  logic [N-1:0]  din_i,
  output logic [V-1:0]  merged_o
);
  logic [V-1:0] vec_q;
  // merged_o is the buffer with the incoming beat already in place, so the final beat commits without an extra cycle
  always_comb begin
    merged_o = vec_q;
    merged_o[idx_i*N +: N] = din_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vec_q <= '0;
    else if (clr_i) vec_q <= '0;
    else if (we_i) vec_q <= merged_o;
  end
endmodule

// File: rtl/writeback_assembler.sv
// writeback_assembler: registers scalar/vector results and assembles vector loads from N-bit beats
module writeback_assembler
  import wb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int V = DEF_V,
  parameter int R = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RegWriteM,
  input  logic         RegWriteVM,
  input  logic         MemtoRegM,
  input  logic [R-1:0] WA3M,
  input  logic [N-1:0] ALUOutM,
  input  logic [V-1:0] ALUOutVM,
  input  logic [N-1:0] ReadDataM,
  input  logic         VecLoadM,
  input  logic         BeatValidM,
  output logic         RegWriteW,
  output logic [R-1:0] WA3W,
  output logic [N-1:0] ResultW,
  output logic         RegWriteVW,
  output logic [V-1:0] ResultVW,
  output logic         StallW
);
  localparam int BT = V / N;
  localparam int CW = cnt_width(BT);
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [R-1:0]  dst_q;
  logic [V-1:0]  merged;
  logic          last;
  assign StallW = state_q == COLLECT;
  assign last = cnt_q == CW'(BT - 1);
  vector_beat_buffer #(.N(N), .V(V), .CW(CW)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == IDLE && VecLoadM),
    .we_i     (state_q == COLLECT && BeatValidM),
    .idx_i    (cnt_q),
    .din_i    (ReadDataM),
    .merged_o (merged)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dst_q      <= '0;
      RegWriteW  <= 1'b0;
      RegWriteVW <= 1'b0;
      WA3W       <= '0;
      ResultW    <= '0;
      ResultVW   <= '0;
    end else if (state_q == IDLE) begin
      RegWriteW  <= RegWriteM;
      ResultW    <= MemtoRegM ? ReadDataM : ALUOutM;
      RegWriteVW <= RegWriteVM & ~VecLoadM;
      ResultVW   <= ALUOutVM;
      WA3W       <= WA3M;
      if (VecLoadM) begin
        dst_q   <= WA3M;
        cnt_q   <= '0;
        state_q <= COLLECT;
      end
    end else begin
      RegWriteW  <= 1'b0;
      RegWriteVW <= 1'b0;
      if (BeatValidM) begin
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          RegWriteVW <= 1'b1;
          ResultVW   <= merged;
          WA3W       <= dst_q;
          state_q    <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_writeback_assembler.sv
// tb_writeback_assembler: scoreboard bench with a beat-queue reference model
module tb_writeback_assembler;
  localparam int N = 32;
  localparam int V = 256;
  localparam int R = 5;
  localparam int BEATS = V / N;
  logic clk = 1'b0, rst = 1'b0;
  logic RegWriteM, RegWriteVM, MemtoRegM, VecLoadM, BeatValidM;
  logic [R-1:0] WA3M;
  logic [N-1:0] ALUOutM, ReadDataM;
  logic [V-1:0] ALUOutVM;
  logic RegWriteW, RegWriteVW, StallW;
  logic [R-1:0] WA3W;
  logic [N-1:0] ResultW;
  logic [V-1:0] ResultVW;
  typedef struct {
    int cyc;
    bit rw;
    bit rvw;
    logic [R-1:0] wa;
    logic [N-1:0] res;
    logic [V-1:0] resv;
  } exp_t;
  exp_t q[$];
  logic [N-1:0] beats[$];
  int tests = 0, fails = 0, edge_n = 0;
  bit m_collect = 0, exp_stall = 0;
  logic [R-1:0] m_dst = '0;
  writeback_assembler #(.N(N), .V(V), .R(R)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .RegWriteVM(RegWriteVM), .MemtoRegM(MemtoRegM),
    .WA3M(WA3M), .ALUOutM(ALUOutM), .ALUOutVM(ALUOutVM), .ReadDataM(ReadDataM),
    .VecLoadM(VecLoadM), .BeatValidM(BeatValidM),
    .RegWriteW(RegWriteW), .WA3W(WA3W), .ResultW(ResultW),
    .RegWriteVW(RegWriteVW), .ResultVW(ResultVW), .StallW(StallW)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [V-1:0] rand_vec();
    logic [V-1:0] v;
    for (int i = 0; i < V / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic set_in(input bit rw, input bit rvw, input bit m2r, input logic [R-1:0] wa,
                        input logic [N-1:0] alu, input logic [V-1:0] aluv, input logic [N-1:0] rd,
                        input bit vl, input bit bv);
    RegWriteM = rw; RegWriteVM = rvw; MemtoRegM = m2r; WA3M = wa;
    ALUOutM = alu; ALUOutVM = aluv; ReadDataM = rd; VecLoadM = vl; BeatValidM = bv;
  endtask
  task automatic set_rand(input int vl_pct, input int bv_pct);
    set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), R'($urandom),
           $urandom, rand_vec(), $urandom, $urandom_range(0, 99) < vl_pct,
           $urandom_range(0, 99) < bv_pct);
  endtask
  // Reference: a load is a list of accepted beat words; lane i of the result is the i-th word
  task automatic model();
    logic [V-1:0] v;
    edge_n++;
    if (!m_collect) begin
      if (RegWriteM || (RegWriteVM && !VecLoadM))
        q.push_back('{edge_n, RegWriteM, RegWriteVM && !VecLoadM, WA3M,
                      MemtoRegM ? ReadDataM : ALUOutM, ALUOutVM});
      if (VecLoadM) begin
        m_collect = 1;
        m_dst = WA3M;
        beats.delete();
      end
    end else if (BeatValidM) begin
      beats.push_back(ReadDataM);
      if (beats.size() == BEATS) begin
        v = '0;
        foreach (beats[i]) v[i*N +: N] = beats[i];
        q.push_back('{edge_n, 1'b0, 1'b1, m_dst, '0, v});
        m_collect = 0;
      end
    end
    exp_stall = m_collect;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) model();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b0;
    q.delete();
    beats.delete();
    m_collect = 0;
    exp_stall = 0;
    repeat (n) begin
      set_rand(50, 50);
      @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", V'({RegWriteW, RegWriteVW, StallW, WA3W}), '0);
      chk("reset_ResultW", V'(ResultW), '0);
      chk("reset_ResultVW", ResultVW, '0);
      #1;
    end
    rst = 1'b1;
  endtask
  task automatic idle();
    set_in(0, 0, 0, '0, '0, '0, '0, 0, 0);
  endtask
  // Ignored inputs are driven busy during collection to prove they have no effect
  task automatic load(input logic [R-1:0] wa, input logic [N-1:0] base, input int gap_a,
                      input int gap_b, input bit scalar, input int nbeats);
    set_in(scalar, 0, 0, wa, 32'h11, rand_vec(), 32'hFFFF_FFFF, 1, 1);
    tick();
    for (int b = 0; b < nbeats; b++) begin
      set_in(1, 1, 1, R'($urandom), $urandom, rand_vec(), base + N'(b), 1, 1);
      tick();
      if (b == gap_a || b == gap_b) begin
        set_in(1, 1, 0, R'($urandom), $urandom, rand_vec(), $urandom, 1, 0);
        tick();
      end
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("StallW", V'(StallW), V'(exp_stall));
      while (q.size() > 0 && q[0].cyc < edge_n) begin
        chk("missed_write_cycle", V'(edge_n), V'(q[0].cyc));
        void'(q.pop_front());
      end
      if (RegWriteW || RegWriteVW) begin
        if (q.size() == 0) chk("spurious_write", V'({RegWriteW, RegWriteVW}), '0);
        else begin
          e = q.pop_front();
          chk("write_cycle", V'(edge_n), V'(e.cyc));
          chk("RegWriteW", V'(RegWriteW), V'(e.rw));
          chk("RegWriteVW", V'(RegWriteVW), V'(e.rvw));
          chk("WA3W", V'(WA3W), V'(e.wa));
          if (e.rw) chk("ResultW", V'(ResultW), V'(e.res));
          if (e.rvw) chk("ResultVW", ResultVW, e.resv);
        end
      end
    end
  end
  initial begin
    idle();
    @(negedge clk);
    #1;
    do_reset(3);
    set_in(1, 0, 0, 3, 32'hDEADBEEF, '0, 32'h0, 0, 0); tick();
    set_in(1, 0, 1, 5, 32'h0, '0, 32'h12345678, 0, 0); tick();
    set_in(0, 1, 0, 7, 32'h0, {32{8'hA5}}, 32'h0, 0, 0); tick();
    idle(); tick();
    load(9, 32'h0, -1, -1, 0, BEATS); idle(); tick();
    load(9, 32'h0, 2, 5, 0, BEATS); idle(); tick();
    load(4, 32'h40, -1, 3, 1, BEATS); idle(); tick();
    load(12, 32'h80, -1, -1, 0, 4);
    do_reset(2);
    load(13, 32'h100, 0, -1, 0, BEATS); idle(); tick();
    repeat (300) begin
      set_rand(15, 65);
      tick();
    end
    do_reset(1);
    repeat (200) begin
      set_rand(20, 80);
      tick();
    end
    idle();
    repeat (3 * BEATS) begin
      BeatValidM = 1'b1;
      ReadDataM = $urandom;
      tick();
    end
    idle();
    repeat (3) tick();
    chk("queue_drained", V'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
